mix_matrix_row_sequencer: RTL and testbench



---
 rtl/mix_matrix_row_sequencer.sv | 118 +++++++++++
 tb/tb_mix_matrix_row_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mix_matrix_row_sequencer.sv
// Streams AES MixColumns / InvMixColumns coefficient rows, one row per beat, NUM_COLS sweeps per start.
// IDLE | waiting for a start handshake     RUN | streaming rows under valid/ready
module mix_matrix_row_sequencer #(
  parameter int                     ELEM_W   = 8,
  parameter logic [4*ELEM_W-1:0]    FWD_ROW0 = {8'h02, 8'h03, 8'h01, 8'h01},
  parameter logic [4*ELEM_W-1:0]    INV_ROW0 = {8'h0E, 8'h0B, 8'h0D, 8'h09},
  parameter int                     NUM_COLS = 4,
  localparam int                    CW       = (NUM_COLS == 1) ? 1 : $clog2(NUM_COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_valid,
  output logic              o_start_ready,
  input  logic              i_mode,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ELEM_W-1:0] o_out1,
  output logic [ELEM_W-1:0] o_out2,
  output logic [ELEM_W-1:0] o_out3,
  output logic [ELEM_W-1:0] o_out4,
  output logic [1:0]        o_row_index,
  output logic [CW-1:0]     o_col_index,
  output logic              o_last
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  state_t              r_state;
  logic                r_mode;
  logic                r_valid;
  logic                r_last;
  logic [1:0]          r_row;
  logic [CW-1:0]       r_col;
  logic [4*ELEM_W-1:0] r_coef;

  logic [1:0]          w_row_nxt;
  logic [CW-1:0]       w_col_nxt;
  logic                w_last_nxt;
  logic [4*ELEM_W-1:0] w_start_coef;
  logic [4*ELEM_W-1:0] w_run_coef;

  // Row r is row 0 rotated right by r elements; element 0 sits in the MSBs.
  function automatic logic [4*ELEM_W-1:0] f_rot(input logic [4*ELEM_W-1:0] row0,
                                                input logic [1:0] r);
    logic [4*ELEM_W-1:0] res;
    int s;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      s = (c - int'(r)) & 3;
      res[(3-c)*ELEM_W +: ELEM_W] = row0[(3-s)*ELEM_W +: ELEM_W];
    end
    return res;
  endfunction

  always_comb begin
    w_row_nxt    = r_row + 2'd1;
    w_col_nxt    = (r_row == 2'd3) ? r_col + CW'(1) : r_col;
    w_last_nxt   = (w_row_nxt == 2'd3) && (w_col_nxt == LAST_COL);
    w_start_coef = f_rot(i_mode ? INV_ROW0 : FWD_ROW0, 2'd0);
    w_run_coef   = f_rot(r_mode ? INV_ROW0 : FWD_ROW0, w_row_nxt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_row   <= 2'd0;
      r_col   <= '0;
      r_coef  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start_valid) begin
            r_state <= S_RUN;
            r_mode  <= i_mode;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_row   <= 2'd0;
            r_col   <= '0;
            r_coef  <= w_start_coef;
          end
        end
        S_RUN: begin
          if (i_out_ready) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_row   <= 2'd0;
              r_col   <= '0;
            end else begin
              r_row  <= w_row_nxt;
              r_col  <= w_col_nxt;
              r_last <= w_last_nxt;
              r_coef <= w_run_coef;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_start_ready = (r_state == S_IDLE) & ~i_rst;
  assign o_out_valid   = r_valid;
  assign o_last        = r_last;
  assign o_row_index   = r_row;
  assign o_col_index   = r_col;
  assign o_out1        = r_coef[4*ELEM_W-1 -: ELEM_W];
  assign o_out2        = r_coef[3*ELEM_W-1 -: ELEM_W];
  assign o_out3        = r_coef[2*ELEM_W-1 -: ELEM_W];
  assign o_out4        = r_coef[ELEM_W-1   -: ELEM_W];

endmodule

// File: tb/tb_mix_matrix_row_sequencer.sv
// Directed bench: one instance with a single column sweep, one with four.
module tb_mix_matrix_row_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sv1 = 0, md1 = 0, or1 = 1, sr1, ov1, la1;
  logic [7:0] a1, b1, c1, d1;
  logic [1:0] ri1;
  logic       ci1;
  logic sv4 = 0, md4 = 0, or4 = 1, sr4, ov4, la4;
  logic [7:0] a4, b4, c4, d4;
  logic [1:0] ri4, ci4;

  wire [31:0] w1 = {a1, b1, c1, d1};
  wire [31:0] w4 = {a4, b4, c4, d4};

  logic [31:0] FWD [4] = '{32'h02030101, 32'h01020301, 32'h01010203, 32'h03010102};
  logic [31:0] INV [4] = '{32'h0E0B0D09, 32'h090E0B0D, 32'h0D090E0B, 32'h0B0D090E};

  int n_checks = 0;
  int n_fail   = 0;

  mix_matrix_row_sequencer #(.NUM_COLS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start_valid(sv1), .o_start_ready(sr1), .i_mode(md1),
    .o_out_valid(ov1), .i_out_ready(or1), .o_out1(a1), .o_out2(b1), .o_out3(c1), .o_out4(d1),
    .o_row_index(ri1), .o_col_index(ci1), .o_last(la1));

  mix_matrix_row_sequencer #(.NUM_COLS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start_valid(sv4), .o_start_ready(sr4), .i_mode(md4),
    .o_out_valid(ov4), .i_out_ready(or4), .o_out1(a4), .o_out2(b4), .o_out3(c4), .o_out4(d4),
    .o_row_index(ri4), .o_col_index(ci4), .o_last(la4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sv1 = 1; sv4 = 1;
    repeat (3) begin
      step();
      n_checks++; if (sr4 !== 1'b0) begin n_fail++; $display("FAIL reset_start_ready got %b exp 0", sr4); end
      n_checks++; if (sr1 !== 1'b0) begin n_fail++; $display("FAIL reset_start_ready1 got %b exp 0", sr1); end
      n_checks++; if (ov4 !== 1'b0 || ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b exp 0", ov1, ov4); end
      n_checks++; if ({w4, ri4, ci4, la4} !== 37'd0) begin n_fail++; $display("FAIL reset_outputs got %h %0d %0d %b exp 0", w4, ri4, ci4, la4); end
    end
    sv1 = 0; sv4 = 0; rst = 0;
    #1;
    n_checks++; if (sr1 !== 1'b1 || sr4 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b/%b exp 1", sr1, sr4); end
    step();
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got %b exp 0", ov4); end
  endtask

  task automatic test_fwd_single();
    md1 = 0; or1 = 1; sv1 = 1;
    step();
    sv1 = 0;
    for (int b = 0; b < 4; b++) begin
      n_checks++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL fwd_valid beat %0d got %b exp 1", b, ov1); end
      n_checks++; if (w1 !== FWD[b]) begin n_fail++; $display("FAIL fwd_coef beat %0d got %h exp %h", b, w1, FWD[b]); end
      n_checks++; if (ri1 !== 2'(b)) begin n_fail++; $display("FAIL fwd_row beat %0d got %0d exp %0d", b, ri1, b); end
      n_checks++; if (la1 !== (b == 3)) begin n_fail++; $display("FAIL fwd_last beat %0d got %b exp %b", b, la1, b == 3); end
      step();
    end
    n_checks++; if (ov1 !== 1'b0 || sr1 !== 1'b1) begin n_fail++; $display("FAIL fwd_end got valid %b ready %b exp 0/1", ov1, sr1); end
  endtask

  task automatic test_inverse();
    md4 = 1; or4 = 1; sv4 = 1;
    step();
    sv4 = 0;
    for (int b = 0; b < 16; b++) begin
      md4 = ~md4;
      n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL inv_valid beat %0d got %b exp 1", b, ov4); end
      n_checks++; if (w4 !== INV[b%4]) begin n_fail++; $display("FAIL inv_coef beat %0d got %h exp %h", b, w4, INV[b%4]); end
      n_checks++; if (ri4 !== 2'(b%4) || ci4 !== 2'(b/4)) begin n_fail++; $display("FAIL inv_index beat %0d got r%0d c%0d exp r%0d c%0d", b, ri4, ci4, b%4, b/4); end
      n_checks++; if (la4 !== (b == 15)) begin n_fail++; $display("FAIL inv_last beat %0d got %b exp %b", b, la4, b == 15); end
      step();
    end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL inv_end got valid %b exp 0", ov4); end
    md4 = 0;
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic stalled = 0;
    logic rdy;
    logic [36:0] prev = '0;
    md4 = 0; or4 = 0; sv4 = 1;
    step();
    sv4 = 0;
    for (int cyc = 0; cyc < 300 && n < 16; cyc++) begin
      if (ov4) begin
        n_checks++; if (w4 !== FWD[n%4]) begin n_fail++; $display("FAIL bp_coef beat %0d got %h exp %h", n, w4, FWD[n%4]); end
        n_checks++; if (ri4 !== 2'(n%4) || ci4 !== 2'(n/4)) begin n_fail++; $display("FAIL bp_index beat %0d got r%0d c%0d exp r%0d c%0d", n, ri4, ci4, n%4, n/4); end
        n_checks++; if (la4 !== (n == 15)) begin n_fail++; $display("FAIL bp_last beat %0d got %b exp %b", n, la4, n == 15); end
        if (stalled) begin
          n_checks++; if ({w4, ri4, ci4, la4} !== prev) begin n_fail++; $display("FAIL bp_stall_hold got %h exp %h", {w4, ri4, ci4, la4}, prev); end
        end
        prev = {w4, ri4, ci4, la4};
        rdy = 1'($urandom_range(0, 1));
        or4 = rdy;
        stalled = ~rdy;
        if (rdy) n++;
      end else begin
        n_checks++; n_fail++; $display("FAIL bp_valid_gap beat %0d got valid 0 exp 1", n);
        or4 = 1;
      end
      step();
    end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL bp_beat_count got %0d exp 16", n); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL bp_end got valid %b exp 0", ov4); end
    or4 = 1;
  endtask

  task automatic test_midrun_reset();
    md4 = 1; or4 = 1; sv4 = 1;
    step();
    sv4 = 0;
    for (int b = 0; b < 6; b++) begin
      n_checks++; if (w4 !== INV[b%4] || ci4 !== 2'(b/4)) begin n_fail++; $display("FAIL mr_beat %0d got %h c%0d exp %h c%0d", b, w4, ci4, INV[b%4], b/4); end
      if (b == 5) rst = 1;
      step();
    end
    n_checks++; if (ov4 !== 1'b0 || w4 !== 32'd0 || la4 !== 1'b0) begin n_fail++; $display("FAIL mr_abort got valid %b coef %h last %b exp 0", ov4, w4, la4); end
    rst = 0;
    #1;
    n_checks++; if (sr4 !== 1'b1) begin n_fail++; $display("FAIL mr_ready got %b exp 1", sr4); end
    step();
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL mr_no_beat7 got valid %b exp 0", ov4); end
    md4 = 0; sv4 = 1;
    step();
    sv4 = 0;
    n_checks++; if (ov4 !== 1'b1 || w4 !== FWD[0] || ri4 !== 2'd0 || ci4 !== 2'd0) begin n_fail++; $display("FAIL mr_restart got v%b %h r%0d c%0d exp v1 %h r0 c0", ov4, w4, ri4, ci4, FWD[0]); end
    repeat (16) step();
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL mr_drain got valid %b exp 0", ov4); end
  endtask

  task automatic test_back_to_back();
    int b;
    md1 = 0; or1 = 1; sv1 = 1;
    step();
    for (int s = 1; s < 10; s++) begin
      if (s == 5) begin
        n_checks++; if (ov1 !== 1'b0 || sr1 !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got valid %b ready %b exp 0/1", ov1, sr1); end
      end else begin
        b = (s < 5) ? s - 1 : s - 6;
        n_checks++; if (ov1 !== 1'b1 || w1 !== FWD[b]) begin n_fail++; $display("FAIL b2b_beat slot %0d got v%b %h exp v1 %h", s, ov1, w1, FWD[b]); end
        n_checks++; if (ri1 !== 2'(b) || la1 !== (b == 3)) begin n_fail++; $display("FAIL b2b_index slot %0d got r%0d l%b exp r%0d l%b", s, ri1, la1, b, b == 3); end
      end
      if (s == 9) sv1 = 0;
      step();
    end
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL b2b_end got valid %b exp 0", ov1); end
    step();
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got valid %b exp 0", ov1); end
  endtask

  initial begin
    test_reset();
    test_fwd_single();
    step();
    test_inverse();
    step();
    test_backpressure();
    step();
    test_midrun_reset();
    step();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
